ram8_port_ctrl: RTL and testbench



---
 rtl/ram8_port_ctrl_pkg.sv | 24 ++
 rtl/ram8_port_ctrl_if.sv | 26 ++
 rtl/ram8_port_ctrl.sv | 128 ++++++++++++
 tb/tb_ram8_port_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram8_port_ctrl_pkg.sv
// Shared definitions for the RAM8 port controller: default widths, request
// opcodes and controller state encodings.
package ram8_port_ctrl_pkg;

   localparam int DATA_W_DEF     = 16;
   localparam int ADDR_W_DEF     = 3;
   localparam int RAM_ADDR_W_DEF = 4;

   typedef enum logic [1:0] {
      OP_READ    = 2'b00,
      OP_WRITE   = 2'b01,
      OP_FILL    = 2'b10,
      OP_ILLEGAL = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_WRITE,
      ST_FILL,
      ST_RESP
   } state_e;

endpackage

// File: rtl/ram8_port_ctrl_if.sv
// Request/response handshake bundle between a client (master) and the
// RAM8 port controller (slave).
interface ram8_port_ctrl_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
);
   logic              req_valid;
   logic              req_ready;
   logic [1:0]        req_op;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_data;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_err;

   modport master (
      output req_valid, req_op, req_addr, req_data, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_err
   );

   modport slave (
      input  req_valid, req_op, req_addr, req_data, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_err
   );
endinterface

// File: rtl/ram8_port_ctrl.sv
// Initiator-side controller for the 8x16 RAM8 block: turns read/write/fill
// requests into registered inp/load/addr sequences and returns one response each.
module ram8_port_ctrl
   import ram8_port_ctrl_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int RAM_ADDR_W = RAM_ADDR_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   ram8_port_ctrl_if.slave       bus,
   output logic [DATA_W-1:0]     ram_inp,
   output logic                  ram_load,
   output logic [RAM_ADDR_W-1:0] ram_addr,
   input  logic [DATA_W-1:0]     ram_out
);

   localparam logic [ADDR_W-1:0] CNT_LAST = '1;

   state_e                  state_q;
   logic                    req_ready_q;
   logic                    rsp_valid_q;
   logic                    rsp_err_q;
   logic [DATA_W-1:0]       rsp_data_q;
   logic [DATA_W-1:0]       data_q;
   logic [ADDR_W-1:0]       cnt_q;
   logic [ADDR_W-1:0]       cnt_nxt;
   logic                    ram_load_q;
   logic [RAM_ADDR_W-1:0]   ram_addr_q;
   logic [DATA_W-1:0]       ram_inp_q;

   assign cnt_nxt = cnt_q + ADDR_W'(1);

   // NOTE: RAM pins are set up one edge early from registered state, so the
   // RAM never sees a combinational path from req_* and load drops on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_data_q  <= '0;
         data_q      <= '0;
         cnt_q       <= '0;
         ram_load_q  <= 1'b0;
         ram_addr_q  <= '0;
         ram_inp_q   <= '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (bus.req_valid && req_ready_q) begin
                  req_ready_q <= 1'b0;
                  data_q      <= bus.req_data;
                  case (op_e'(bus.req_op))
                     OP_READ: begin
                        ram_addr_q <= RAM_ADDR_W'(bus.req_addr);
                        state_q    <= ST_READ;
                     end
                     OP_WRITE: begin
                        ram_addr_q <= RAM_ADDR_W'(bus.req_addr);
                        ram_inp_q  <= bus.req_data;
                        ram_load_q <= 1'b1;
                        state_q    <= ST_WRITE;
                     end
                     OP_FILL: begin
                        cnt_q      <= '0;
                        ram_addr_q <= '0;
                        ram_inp_q  <= bus.req_data;
                        ram_load_q <= 1'b1;
                        state_q    <= ST_FILL;
                     end
                     default: begin
                        rsp_data_q  <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
                     end
                  endcase
               end
            end
            ST_READ: begin
               rsp_data_q  <= ram_out;
               rsp_err_q   <= 1'b0;
               rsp_valid_q <= 1'b1;
               state_q     <= ST_RESP;
            end
            ST_WRITE: begin
               ram_load_q  <= 1'b0;
               rsp_data_q  <= data_q;
               rsp_err_q   <= 1'b0;
               rsp_valid_q <= 1'b1;
               state_q     <= ST_RESP;
            end
            ST_FILL: begin
               if (cnt_q == CNT_LAST) begin
                  ram_load_q  <= 1'b0;
                  cnt_q       <= '0;
                  rsp_data_q  <= data_q;
                  rsp_err_q   <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  state_q     <= ST_RESP;
               end else begin
                  cnt_q      <= cnt_nxt;
                  ram_addr_q <= RAM_ADDR_W'(cnt_nxt);
               end
            end
            ST_RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
                  state_q     <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.req_ready = req_ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.rsp_data  = rsp_data_q;
   assign ram_load      = ram_load_q;
   assign ram_addr      = ram_addr_q;
   assign ram_inp       = ram_inp_q;

endmodule

// File: tb/tb_ram8_port_ctrl.sv
// Scoreboard bench for ram8_port_ctrl driving a behavioural 8x16 RAM8 model.
module tb_ram8_port_ctrl;

   typedef struct packed {
      logic [15:0] data;
      logic        err;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic [15:0] ram_inp;
   logic        ram_load;
   logic [3:0]  ram_addr;
   logic [15:0] ram_out;

   logic [15:0] mem [8];
   logic [15:0] ref_mem [8];
   exp_t        sb [$];
   logic [3:0]  load_addrs [$];
   int          n_cmp, n_err, cyc, rsp_mode, acc_cyc;

   ram8_port_ctrl_if #(.DATA_W(16), .ADDR_W(3)) bus ();

   ram8_port_ctrl dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .ram_inp  (ram_inp),
      .ram_load (ram_load),
      .ram_addr (ram_addr),
      .ram_out  (ram_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) if (ram_load) mem[ram_addr[2:0]] <= ram_inp;
   assign ram_out = mem[ram_addr[2:0]];

   initial begin
      cyc = 0;
      forever begin @(posedge clk); cyc++; end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Response monitor: compares every completed handshake against the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) begin
               check("rsp_unexpected", 1, 0);
            end else begin
               e = sb.pop_front();
               check("rsp_data", bus.rsp_data, e.data);
               check("rsp_err", bus.rsp_err, e.err);
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (ram_load) load_addrs.push_back(ram_addr);
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (rsp_mode)
            0:       bus.rsp_ready = ($urandom_range(0, 3) != 0);
            1:       bus.rsp_ready = 1'b0;
            default: bus.rsp_ready = 1'b1;
         endcase
      end
   end

   function automatic int exp_latency(input logic [1:0] op);
      case (op)
         2'b10:   return 9;
         2'b11:   return 1;
         default: return 2;
      endcase
   endfunction

   task automatic issue(input logic [1:0] op, input logic [2:0] addr, input logic [15:0] data);
      exp_t e;
      int   guard;
      int   lat;
      guard = 0;
      @(negedge clk);
      while (!bus.req_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (!bus.req_ready) begin
         check("req_ready_timeout", 0, 1);
         return;
      end
      case (op)
         2'b00: e = '{data: ref_mem[addr], err: 1'b0};
         2'b01: begin e = '{data: data, err: 1'b0}; ref_mem[addr] = data; end
         2'b10: begin
            e = '{data: data, err: 1'b0};
            for (int i = 0; i < 8; i++) ref_mem[i] = data;
         end
         default: e = '{data: 16'h0000, err: 1'b1};
      endcase
      sb.push_back(e);
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_addr  = addr;
      bus.req_data  = data;
      @(posedge clk);
      #1;
      acc_cyc       = cyc;
      bus.req_valid = 1'b0;
      bus.req_op    = 2'($urandom);
      bus.req_addr  = 3'($urandom);
      bus.req_data  = 16'($urandom);
      load_addrs.delete();
      lat = 1;
      while (!bus.rsp_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("latency", lat, exp_latency(op));
      case (op)
         2'b01: begin
            check("write_load_cycles", load_addrs.size(), 1);
            if (load_addrs.size() > 0) check("write_load_addr", load_addrs[0], {1'b0, addr});
         end
         2'b10: begin
            check("fill_load_cycles", load_addrs.size(), 8);
            for (int i = 0; i < 8 && i < load_addrs.size(); i++)
               check("fill_load_addr", load_addrs[i], i);
         end
         default: check("no_load", load_addrs.size(), 0);
      endcase
   endtask

   task automatic drain();
      int guard;
      rsp_mode = 2;
      guard = 0;
      @(negedge clk);
      while (!(sb.size() == 0 && bus.req_ready) && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 100) check("drain_timeout", 0, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int acc [4];
      n_cmp         = 0;
      n_err         = 0;
      rsp_mode      = 2;
      rst_n         = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_op    = 2'b00;
      bus.req_addr  = '0;
      bus.req_data  = '0;
      bus.rsp_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin mem[i] = '0; ref_mem[i] = '0; end

      #12;
      check("rst_req_ready", bus.req_ready, 1);
      check("rst_rsp_valid", bus.rsp_valid, 0);
      check("rst_rsp_err", bus.rsp_err, 0);
      check("rst_rsp_data", bus.rsp_data, 0);
      check("rst_ram_load", ram_load, 0);
      check("rst_ram_addr", ram_addr, 0);
      check("rst_ram_inp", ram_inp, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Directed: write/read, fill/sweep, illegal op.
      issue(2'b01, 3'd3, 16'hBEEF);
      issue(2'b00, 3'd3, 16'h0000);
      issue(2'b10, 3'd0, 16'h5A5A);
      for (int a = 0; a < 8; a++) issue(2'b00, 3'(a), 16'h0000);
      issue(2'b11, 3'd2, 16'h1234);

      // Backpressure on a read.
      drain();
      rsp_mode = 1;
      @(posedge clk);
      #2;
      issue(2'b00, 3'd5, 16'h0000);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("bp_rsp_valid", bus.rsp_valid, 1);
         check("bp_rsp_data", bus.rsp_data, ref_mem[5]);
         check("bp_req_ready", bus.req_ready, 0);
      end
      rsp_mode = 2;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      check("bp_release_req_ready", bus.req_ready, 1);
      check("bp_release_rsp_valid", bus.rsp_valid, 0);

      // Back-to-back with the consumer always ready.
      drain();
      issue(2'b01, 3'd7, 16'h0001); acc[0] = acc_cyc;
      issue(2'b00, 3'd7, 16'h0000); acc[1] = acc_cyc;
      issue(2'b01, 3'd7, 16'hFFFF); acc[2] = acc_cyc;
      issue(2'b00, 3'd7, 16'h0000); acc[3] = acc_cyc;
      for (int i = 1; i < 4; i++) check("b2b_spacing", acc[i] - acc[i-1], 3);

      // Randomized mix with random backpressure.
      rsp_mode = 0;
      for (int n = 0; n < 60; n++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r < 4)       issue(2'b00, 3'($urandom), 16'h0000);
         else if (r < 7)  issue(2'b01, 3'($urandom), 16'($urandom));
         else if (r == 7) issue(2'b10, 3'($urandom), 16'($urandom));
         else             issue(2'b11, 3'($urandom), 16'($urandom));
      end

      // Reset during the cnt=4 cycle of a fill.
      drain();
      for (int a = 0; a < 8; a++) issue(2'b01, 3'(a), 16'(a * 16'h1111 + 16'h0001));
      drain();
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_op    = 2'b10;
      bus.req_addr  = 3'd0;
      bus.req_data  = 16'hA5C3;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      check("mid_fill_addr", ram_addr, 4);
      check("mid_fill_load", ram_load, 1);
      rst_n = 1'b0;
      #1;
      check("rst_drops_load", ram_load, 0);
      for (int i = 0; i < 4; i++) ref_mem[i] = 16'hA5C3;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_req_ready", bus.req_ready, 1);
      check("post_rst_rsp_valid", bus.rsp_valid, 0);
      for (int a = 0; a < 8; a++) issue(2'b00, 3'(a), 16'h0000);

      drain();
      check("sb_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
